// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, one-hot state
// encoding and the load-data extension helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_BUS  = 3'b010,
        S_DONE = 3'b100
    } lsu_state_t;

    function automatic logic [31:0] lsu_extend(input logic [2:0] funct3,
                                               input logic [31:0] value);
        logic [31:0] res;
        case (funct3)
            F3_B:    res = {{24{value[7]}}, value[7:0]};
            F3_BU:   res = {24'd0, value[7:0]};
            F3_H:    res = {{16{value[15]}}, value[15:0]};
            F3_HU:   res = {16'd0, value[15:0]};
            default: res = value;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Turns one RV32E load/store into a single mem_bus transaction, with
// alignment/range checking and a one-cycle completion pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_SIZE = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_valid,
    input  logic                    cpu_write,
    input  logic [2:0]              cpu_funct3,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_done,
    output logic                    cpu_err,
    output logic [31:0]             cpu_rdata,
    output logic [ADDRESS_SIZE-1:0] target_address,
    output logic [2:0]              num_bytes,
    output logic                    is_write,
    output logic [31:0]             write_value,
    output logic                    start_request,
    input  logic                    request_done,
    input  logic [31:0]             fetched_value,
    output lsu_state_t              dbg_state
);

    // Handshake: a request is taken on a clock edge where cpu_valid and
    // cpu_ready are both high; the CPU holds it stable until then. On the
    // bus side start_request is a level held until the edge that sees
    // request_done, and is always low for at least one cycle afterwards.

    lsu_state_t  state;
    logic [2:0]  op_funct3;
    logic [2:0]  req_size;
    logic        req_legal;

    assign cpu_ready = (state == S_IDLE);
    assign dbg_state = state;

    always_comb begin
        req_size  = 3'd0;
        req_legal = 1'b1;
        case (cpu_funct3)
            F3_B, F3_BU: req_size = 3'd1;
            F3_H, F3_HU: req_size = 3'd2;
            F3_W:        req_size = 3'd4;
            default:     req_legal = 1'b0;
        endcase
        if ((cpu_funct3 == F3_H || cpu_funct3 == F3_HU) && cpu_addr[0])
            req_legal = 1'b0;
        if (cpu_funct3 == F3_W && cpu_addr[1:0] != 2'b00)
            req_legal = 1'b0;
        // Unsigned variants have no meaning for stores.
        if (cpu_write && (cpu_funct3 == F3_BU || cpu_funct3 == F3_HU))
            req_legal = 1'b0;
        if (cpu_addr[31:ADDRESS_SIZE] != '0)
            req_legal = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            op_funct3      <= 3'd0;
            cpu_done       <= 1'b0;
            cpu_err        <= 1'b0;
            cpu_rdata      <= 32'd0;
            target_address <= '0;
            num_bytes      <= 3'd0;
            is_write       <= 1'b0;
            write_value    <= 32'd0;
            start_request  <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        if (req_legal) begin
                            target_address <= cpu_addr[ADDRESS_SIZE-1:0];
                            num_bytes      <= req_size;
                            is_write       <= cpu_write;
                            write_value    <= cpu_wdata;
                            op_funct3      <= cpu_funct3;
                            start_request  <= 1'b1;
                            state          <= S_BUS;
                        end else begin
                            // Bus outputs are left untouched on a rejected request.
                            cpu_err  <= 1'b1;
                            cpu_done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_BUS: begin
                    if (request_done) begin
                        cpu_rdata     <= is_write ? 32'd0 : lsu_extend(op_funct3, fetched_value);
                        cpu_err       <= 1'b0;
                        cpu_done      <= 1'b1;
                        start_request <= 1'b0;
                        state         <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the RV32E execute stage and `mem_bus`, directly upstream of it. Converts one CPU load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) into a single `mem_bus` transaction. It checks alignment and range, drives the `start_request`/`request_done` handshake including the mandatory release cycle, and returns sign- or zero-extended load data with a one-cycle completion pulse.

## Interface
- `ADDRESS_SIZE`, 18, width of the bus address. MSB = 1 selects IO; bit `ADDRESS_SIZE-2` selects RAM (1) or flash (0).
- `clk` in 1 clock
- `rst_n` in 1 reset, synchronous, active-low
- `cpu_valid` in 1 request strobe; sampled only while `cpu_ready`=1
- `cpu_write` in 1 1 = store, 0 = load
- `cpu_funct3` in 3 RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `cpu_addr` in 32 byte address
- `cpu_wdata` in 32 store data, right-aligned
- `cpu_ready` out 1 high in IDLE (combinational from state)
- `cpu_done` out 1 one-cycle completion pulse
- `cpu_err` out 1 valid with `cpu_done`; misaligned, out-of-range, or illegal funct3
- `cpu_rdata` out 32 extended load data; valid with `cpu_done`, held until next `cpu_done`
- `target_address` out ADDRESS_SIZE bus address
- `num_bytes` out 3 transfer size: 1, 2, or 4
- `is_write` out 1 bus write
- `write_value` out 32 bus write data
- `start_request` out 1 bus request, level
- `request_done` in 1 bus completion
- `fetched_value` in 32 bus read data; byte at lowest address in [7:0]

## Operation
- States: IDLE, BUS, DONE.
- IDLE → BUS when `cpu_valid` is high and the request is legal. On entry:
  - latch `target_address = cpu_addr[ADDRESS_SIZE-1:0]`, `num_bytes`, `is_write = cpu_write`, `write_value = cpu_wdata` (unmasked; bus uses the low `num_bytes` bytes);
  - set `start_request` to 1.
- Illegal request:
  - H/HU with `addr[0]`=1;
  - W with `addr[1:0]`≠0;
  - funct3 ∈ {011, 110, 111};
  - store with funct3 100 or 101;
  - `cpu_addr[31:ADDRESS_SIZE]` ≠ 0.
- Illegal request handling: IDLE → DONE with `cpu_err`=1, `start_request` never raised, bus outputs unchanged.
- BUS: hold all bus outputs stable. On an edge with `request_done`=1:
  - capture and extend `fetched_value`: B sign-extends [7:0], BU zero-extends [7:0], H sign-extends [15:0], HU zero-extends [15:0], W takes all 32 bits;
  - stores set `cpu_rdata` to 0;
  - clear `start_request`; go to DONE.
- DONE: `cpu_done`=1 for exactly one cycle; `start_request`=0, which guarantees the `mem_bus` internal state returns to PARSE; → IDLE.
- `cpu_valid` outside IDLE is ignored. The CPU must hold the request until `cpu_ready`.
- Reset values: `start_request`, `cpu_done`, `cpu_err`, `is_write` = 0. `cpu_rdata`, `target_address`, `num_bytes`, `write_value` = 0. State = IDLE, so `cpu_ready`=1.
- Reset mid-BUS drops `start_request` on the next edge and abandons the transaction with no `cpu_done`.

## Timing
- Accept at edge N. `start_request`=1 from N+1.
- `request_done` seen at edge M. `start_request`=0 and `cpu_done`=1 in cycle M+1. `cpu_ready`=1 in cycle M+2.
- Total latency = bus latency + 2 cycles. Back-to-back requests have ≥1 cycle with `start_request` low between them.
- Error path: accept at N, `cpu_done`/`cpu_err` in cycle N+1, `cpu_ready` in N+2.
- `request_done` while not in BUS is ignored.
- `request_done` already high on the first BUS cycle is legal and completes at that edge.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - state encoding (one-hot, 3 bits);
  - function `lsu_extend(funct3, value)` returning 32-bit extended data.
- No sub-module. Legality check and size decode are combinational logic in the top.

## Test plan
- LW at 0x00000100, bus returns `fetched_value`=0xDEADBEEF after 5 cycles → `num_bytes`=4, `target_address`=0x00100; `cpu_rdata`=0xDEADBEEF with `cpu_done` in cycle M+1.
- LB / LBU at 0x3, `fetched_value`=0x00000080 → 0xFFFFFF80 / 0x00000080. LH / LHU at 0x2 with 0x8001 → 0xFFFF8001 / 0x00008001.
- SH at 0x20000 (IO), wdata 0x12345678 → `is_write`=1, `num_bytes`=2, `write_value`=0x12345678, `target_address`=0x20000; `cpu_rdata`=0, no err.
- LW at 0x2, SH at 0x1, LB at 0x00040000, funct3=011 → each gives `cpu_err`+`cpu_done` one cycle after accept; `start_request` stays 0.
- Two back-to-back SW with `request_done` tied high → `start_request` shows 1,0,…,1 with ≥1 low cycle between.
- Assert `rst_n`=0 in BUS → `start_request`=0 next edge, no `cpu_done`, `cpu_ready`=1.
